// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch front end owning the PC, one outstanding ifetch
// request at a time, and a DEPTH-entry {pc, instr} queue with branch-redirect flush.
`default_nettype none

module fetch_queue #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     ifetch_read,
  output logic [WIDTH-1:0]         ifetch_address,
  input  logic [WIDTH-1:0]         ifetch_rdata,
  input  logic                     ifetch_resp,
  input  logic                     redirect,
  input  logic [WIDTH-1:0]         redirect_pc,
  input  logic                     deq,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_instr,
  output logic [WIDTH-1:0]         out_pc,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DISCARD = 2'd2} state_t;

  state_t           state;
  logic [WIDTH-1:0] fetch_pc;
  logic [WIDTH-1:0] disc_addr;
  logic [WIDTH-1:0] instr_mem [DEPTH];
  logic [WIDTH-1:0] pc_mem    [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [CW-1:0]    count_q;

  logic             push;
  logic             pop;
  logic [CW-1:0]    count_next;
  logic             room;

  // Redirect overrides both enqueue and dequeue in the same cycle.
  assign push       = rst_n && (state == REQ) && ifetch_resp && !redirect;
  assign pop        = deq && (count_q != '0) && !redirect;
  assign count_next = redirect ? '0 : (count_q + CW'(push) - CW'(pop));
  assign room       = count_next < CW'(DEPTH);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      disc_addr <= RESET_PC;
      count_q   <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      count_q  <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      case (state)
        IDLE:    state <= IDLE;
        REQ: begin
          if (ifetch_resp) begin
            state <= REQ;
          end else begin
            disc_addr <= fetch_pc;
            state     <= DISCARD;
          end
        end
        DISCARD: state <= ifetch_resp ? REQ : DISCARD;
        default: state <= IDLE;
      endcase
    end else begin
      count_q <= count_next;
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case (state)
        IDLE: begin
          if (room) state <= REQ;
        end
        REQ: begin
          if (ifetch_resp) begin
            wr_ptr   <= wr_ptr + AW'(1);
            fetch_pc <= fetch_pc + WIDTH'(2);
            state    <= room ? REQ : IDLE;
          end
        end
        DISCARD: begin
          if (ifetch_resp) state <= REQ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Queue storage carries no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= ifetch_rdata;
      pc_mem[wr_ptr]    <= fetch_pc;
    end
  end

  assign ifetch_read    = (state != IDLE);
  assign ifetch_address = (state == DISCARD) ? disc_addr : fetch_pc;
  assign out_valid      = (count_q != '0);
  assign out_instr      = out_valid ? instr_mem[rd_ptr] : '0;
  assign out_pc         = out_valid ? pc_mem[rd_ptr] : '0;
  assign count          = count_q;

endmodule

`default_nettype wire
